uart_rx: RTL and testbench
==========================

# uart_rx

AXI4-Stream UART receiver, the receive half of the UART link alongside the existing transmitter. It synchronises the asynchronous `rxd` line and detects start bits. It samples each bit at mid-period using the shared `prescale` configuration, where one bit lasts `prescale·8` clocks. Received words go out on an AXI4-Stream master with overrun and framing status. Frame format is fixed: 1 start bit, `DATA_WIDTH` data bits LSB-first, 1 stop bit, no parity.

## Interface
- `DATA_WIDTH`, default 8, data bits per frame (5–9 supported).
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `m_axis_tdata`  out  DATA_WIDTH  received word.
- `m_axis_tvalid`  out  1  word available.
- `m_axis_tready`  in  1  downstream accepts.
- `rxd`  in  1  asynchronous serial input, idle high.
- `busy`  out  1  frame reception in progress.
- `overrun_error`  out  1  one-cycle pulse: new word overwrote an unaccepted word.
- `frame_error`  out  1  one-cycle pulse: stop bit sampled low.
- `prescale`  in  16  bit period in units of 8 clocks, shared with the transmitter.

## Operation
- **Reset values** (`rst_n`=0 at a clock edge):
  - sync flops =1, state IDLE, counter 0, bit index 0, `m_axis_tdata`=0.
  - `m_axis_tvalid`, `busy`, `overrun_error` and `frame_error` all =0.
  - Reset mid-frame aborts the frame; no partial word is output.
- **Input synchronisation**: `rxd` passes through a 2-flop synchroniser. `rxd_s` is the second flop; all decisions use `rxd_s`.
- **Timing counter**: 19-bit down-counter.
  - A "sample event" occurs on an edge where the state is not IDLE/WAIT_HIGH and the counter is 0.
  - Loading N−1 places the event N edges later.
- **State machine** (states IDLE, START, DATA, STOP, WAIT_HIGH):
  - IDLE: if `rxd_s`=0 and `prescale`≠0, go to START, load `(prescale<<2)−1` and set `busy`=1. Otherwise stay.
  - `prescale`=0 is illegal: start detection is suppressed.
  - START event, `rxd_s`=0: go to DATA, load `(prescale<<3)−1`, bit index 0.
  - START event, `rxd_s`=1: false start. Go to IDLE with `busy`=0; no status pulse.
  - DATA event: shift `rxd_s` into the MSB of the shift register (LSB-first reception) and load `(prescale<<3)−1`. After bit `DATA_WIDTH−1`, go to STOP.
  - STOP event, `rxd_s`=1: copy the shift register to `m_axis_tdata`, set `m_axis_tvalid`=1, go to IDLE with `busy`=0.
  - Overrun case of the STOP event: if `m_axis_tvalid`=1 and no handshake occurs on the same edge, pulse `overrun_error`. The new word replaces the old one and `tvalid` stays 1.
  - STOP event, `rxd_s`=0: pulse `frame_error`, discard the word, go to WAIT_HIGH. `busy` stays 1.
  - WAIT_HIGH: when `rxd_s`=1, go to IDLE with `busy`=0. This stops a break or stuck-low line from retriggering start detection.
- **Load-time arithmetic**: `prescale` is zero-extended to 19 bits before the shift. A `prescale` change mid-frame takes effect at the next counter load.
- **AXI output**:
  - A handshake (`tvalid`&`tready`) clears `tvalid` on that edge.
  - If a new word is stored on the same edge as a handshake, `tvalid` stays 1 and no overrun is flagged.
  - `tdata` is stable while `tvalid`=1, except on overrun.

## Timing
- Let the first low `rxd` be sampled at edge t, with bit period P=`prescale`, 8P clocks per bit.
- `rxd_s`=0 after edge t+1. IDLE→START on edge t+2.
- Start-bit sample at edge t+2+4P. Data bit k is sampled at t+2+4P+8P·(k+1).
- Stop sample, and `tvalid` rising, at edge t+2+4P+8P·(DATA_WIDTH+1).
- Example: P=1, W=8 gives t+78.
- Back-to-back frames: a start edge arriving 4P clocks after the stop sample (the end of the stop bit) is detected, with no lost frame.
- Status pulses last exactly 1 cycle and are coincident with the stop-sample edge.

## Structure
- Package `uart_pkg` holds:
  - `OVERSAMPLE` = 8;
  - the `rx_state_t` enum (IDLE, START, DATA, STOP, WAIT_HIGH);
  - the counter width constant 19.
- Sub-module `uart_sync2` is the 2-flop synchroniser, reset value parameterised (1 here).
- Remaining logic is one FSM process in `uart_rx`.

## Test plan
- **Single byte**: P=1, `tready`=1, send 0xA5 → `tdata`=0xA5 with `tvalid` high exactly at edge t+78 for one cycle; no status pulses; `busy` high from t+2 to t+78.
- **Back-to-back**: send 0x00 then 0xFF with no idle gap, `tready`=1 → both words delivered in order; no errors.
- **False start**: hold `rxd` low for 3 clocks, P=1 → returns to IDLE at t+6; no `tvalid`, no error.
- **Framing error**: send 0x3C with stop bit low, then `rxd` high → `frame_error` pulse at t+78; no `tvalid`; `busy` falls 1 clock after `rxd_s` goes high.
- **Overrun**: `tready`=0, send 0x11 then 0x22 → one `overrun_error` pulse at the second stop sample; `tdata`=0x22; raising `tready` gives one handshake.
- **Reset mid-frame**: assert `rst_n`=0 during data bit 3, release, send 0x5A → all outputs at reset values during reset; only 0x5A is delivered.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and types for the UART receive path.
//   OVERSAMPLE - clocks per bit per unit of prescale
//   CNT_WIDTH  - width of the bit-timing down-counter
//   rx_state_t - receiver FSM states
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 8;
    localparam int unsigned CNT_WIDTH  = 19;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitHigh
    } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchroniser for a single asynchronous input.
//   clk      - sampling clock
//   rst_n    - synchronous active-low reset, loads ResetVal into both flops
//   d_i      - asynchronous input
//   q_o      - synchronised output (second flop)
module uart_sync2 #(
    parameter logic ResetVal = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], d_i};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {2{ResetVal}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver with AXI4-Stream master output.
// Frame: 1 start bit, DATA_WIDTH data bits LSB-first, 1 stop bit, no parity.
//   clk, rst_n      - clock and synchronous active-low reset
//   m_axis_tdata    - received word
//   m_axis_tvalid   - word available, cleared by handshake
//   m_axis_tready   - downstream accepts
//   rxd             - asynchronous serial input, idle high
//   busy            - frame reception in progress
//   overrun_error   - one-cycle pulse when an unaccepted word is overwritten
//   frame_error     - one-cycle pulse when the stop bit is sampled low
//   prescale        - bit period in units of OVERSAMPLE clocks
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    input  logic                  rxd,
    output logic                  busy,
    output logic                  overrun_error,
    output logic                  frame_error,
    input  logic [15:0]           prescale
);

    localparam int unsigned IdxW = $clog2(DATA_WIDTH);

    logic rxd_s;

    uart_sync2 #(
        .ResetVal(1'b1)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  (rxd),
        .q_o  (rxd_s)
    );

    rx_state_t             state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d;
    logic                  busy_q, busy_d;
    logic                  ovr_q, ovr_d;
    logic                  ferr_q, ferr_d;

    logic [CNT_WIDTH-1:0]  ps_ext;
    logic [CNT_WIDTH-1:0]  load_half;
    logic [CNT_WIDTH-1:0]  load_bit;
    logic                  cnt_zero;

    // Loads are N-1 so the sample event lands N edges after the load.
    assign ps_ext    = {{(CNT_WIDTH - 16){1'b0}}, prescale};
    assign load_half = (ps_ext << ($clog2(OVERSAMPLE) - 1)) - CNT_WIDTH'(1);
    assign load_bit  = (ps_ext << $clog2(OVERSAMPLE)) - CNT_WIDTH'(1);
    assign cnt_zero  = (cnt_q == '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shreg_d  = shreg_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q & ~m_axis_tready;
        busy_d   = busy_q;
        ovr_d    = 1'b0;
        ferr_d   = 1'b0;

        case (state_q)
            StIdle: begin
                // prescale of zero is illegal, so never start a frame with it
                if (!rxd_s && (prescale != 16'd0)) begin
                    state_d = StStart;
                    cnt_d   = load_half;
                    busy_d  = 1'b1;
                end
            end
            StStart: begin
                if (cnt_zero) begin
                    if (!rxd_s) begin
                        state_d = StData;
                        cnt_d   = load_bit;
                        idx_d   = '0;
                    end else begin
                        // glitch shorter than half a bit: false start
                        state_d = StIdle;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            StData: begin
                if (cnt_zero) begin
                    shreg_d = {rxd_s, shreg_q[DATA_WIDTH-1:1]};
                    cnt_d   = load_bit;
                    if (idx_q == IdxW'(DATA_WIDTH - 1)) begin
                        state_d = StStop;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            StStop: begin
                if (cnt_zero) begin
                    if (rxd_s) begin
                        tdata_d  = shreg_q;
                        tvalid_d = 1'b1;
                        ovr_d    = tvalid_q & ~m_axis_tready;
                        state_d  = StIdle;
                        busy_d   = 1'b0;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = StWaitHigh;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            StWaitHigh: begin
                // hold off start detection until a break/stuck-low line releases
                if (rxd_s) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            idx_q    <= '0;
            shreg_q  <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            ovr_q    <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shreg_q  <= shreg_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            busy_q   <= busy_d;
            ovr_q    <= ovr_d;
            ferr_q   <= ferr_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign busy          = busy_q;
    assign overrun_error = ovr_q;
    assign frame_error   = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx (DATA_WIDTH=8, prescale=1).
module tb_uart_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rxd = 1'b1;
    logic        m_axis_tready = 1'b1;
    logic [15:0] prescale = 16'd1;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        busy;
    logic        overrun_error;
    logic        frame_error;

    always #5 clk = ~clk;

    uart_rx #(
        .DATA_WIDTH(8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .rxd          (rxd),
        .busy         (busy),
        .overrun_error(overrun_error),
        .frame_error  (frame_error),
        .prescale     (prescale)
    );

    // Edge index: value of cyc after a rising edge equals that edge's number.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor, sampled on the falling edge.
    int         n_words = 0;
    logic [7:0] words [0:63];
    int         tv_cycles = 0;
    int         ovr_cycles = 0;
    int         ferr_cycles = 0;
    int         tv_rise = -1;
    int         busy_rise = -1;
    int         busy_fall = -1;
    int         ovr_edge = -1;
    int         ferr_edge = -1;
    logic       tv_prev = 1'b0;
    logic       busy_prev = 1'b0;

    always @(negedge clk) begin
        if (m_axis_tvalid && m_axis_tready) begin
            if (n_words < 64) words[n_words] = m_axis_tdata;
            n_words = n_words + 1;
        end
        if (m_axis_tvalid) tv_cycles = tv_cycles + 1;
        if (m_axis_tvalid && !tv_prev) tv_rise = cyc;
        if (busy && !busy_prev) busy_rise = cyc;
        if (!busy && busy_prev) busy_fall = cyc;
        if (overrun_error) begin
            ovr_cycles = ovr_cycles + 1;
            ovr_edge   = cyc;
        end
        if (frame_error) begin
            ferr_cycles = ferr_cycles + 1;
            ferr_edge   = cyc;
        end
        tv_prev   = m_axis_tvalid;
        busy_prev = busy;
    end

    int checks = 0;
    int passes = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) passes = passes + 1;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one frame at prescale=1; t is the edge that first samples the start bit.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, output int t);
        t   = cyc + 1;
        rxd = 1'b0;
        tick(8);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            tick(8);
        end
        rxd = stop_bit;
        tick(8);
        rxd = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t, t1, t2;
        int w0, tv0, ov0, fe0;

        // Reset state
        rst_n = 1'b0;
        tick(3);
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tdata", 32'(m_axis_tdata), 32'd0);
        check("rst_ovr", 32'(overrun_error), 32'd0);
        check("rst_ferr", 32'(frame_error), 32'd0);
        rst_n = 1'b1;
        tick(5);

        // Single byte 0xA5
        w0 = n_words; tv0 = tv_cycles; ov0 = ovr_cycles; fe0 = ferr_cycles;
        send_frame(8'hA5, 1'b1, t);
        tick(4);
        check("single_count", 32'(n_words - w0), 32'd1);
        check("single_data", 32'(words[w0]), 32'hA5);
        check("single_tvalid_edge", 32'(tv_rise), 32'(t + 78));
        check("single_tvalid_width", 32'(tv_cycles - tv0), 32'd1);
        check("single_busy_rise", 32'(busy_rise), 32'(t + 2));
        check("single_busy_fall", 32'(busy_fall), 32'(t + 78));
        check("single_ovr", 32'(ovr_cycles - ov0), 32'd0);
        check("single_ferr", 32'(ferr_cycles - fe0), 32'd0);

        // Back-to-back 0x00 then 0xFF
        w0 = n_words; ov0 = ovr_cycles; fe0 = ferr_cycles;
        send_frame(8'h00, 1'b1, t1);
        send_frame(8'hFF, 1'b1, t2);
        tick(4);
        check("b2b_count", 32'(n_words - w0), 32'd2);
        check("b2b_first", 32'(words[w0]), 32'h00);
        check("b2b_second", 32'(words[w0 + 1]), 32'hFF);
        check("b2b_tvalid_edge", 32'(tv_rise), 32'(t2 + 78));
        check("b2b_errors", 32'((ovr_cycles - ov0) + (ferr_cycles - fe0)), 32'd0);

        // False start: 3 clocks low
        w0 = n_words; ov0 = ovr_cycles; fe0 = ferr_cycles;
        t = cyc + 1;
        rxd = 1'b0;
        tick(3);
        rxd = 1'b1;
        tick(10);
        check("fstart_busy_rise", 32'(busy_rise), 32'(t + 2));
        check("fstart_busy_fall", 32'(busy_fall), 32'(t + 6));
        check("fstart_words", 32'(n_words - w0), 32'd0);
        check("fstart_errors", 32'((ovr_cycles - ov0) + (ferr_cycles - fe0)), 32'd0);

        // Framing error on 0x3C
        w0 = n_words; tv0 = tv_cycles; ov0 = ovr_cycles; fe0 = ferr_cycles;
        send_frame(8'h3C, 1'b0, t);
        tick(6);
        check("ferr_edge", 32'(ferr_edge), 32'(t + 78));
        check("ferr_width", 32'(ferr_cycles - fe0), 32'd1);
        check("ferr_words", 32'(n_words - w0), 32'd0);
        check("ferr_tvalid", 32'(tv_cycles - tv0), 32'd0);
        check("ferr_busy_fall", 32'(busy_fall), 32'(t + 82));
        check("ferr_ovr", 32'(ovr_cycles - ov0), 32'd0);

        // Overrun: 0x11 then 0x22 with tready low
        m_axis_tready = 1'b0;
        w0 = n_words; ov0 = ovr_cycles; fe0 = ferr_cycles;
        send_frame(8'h11, 1'b1, t1);
        send_frame(8'h22, 1'b1, t2);
        tick(2);
        check("ovr_edge", 32'(ovr_edge), 32'(t2 + 78));
        check("ovr_width", 32'(ovr_cycles - ov0), 32'd1);
        check("ovr_tvalid", 32'(m_axis_tvalid), 32'd1);
        check("ovr_tdata", 32'(m_axis_tdata), 32'h22);
        check("ovr_no_hs", 32'(n_words - w0), 32'd0);
        m_axis_tready = 1'b1;
        tick(1);
        check("ovr_tvalid_clr", 32'(m_axis_tvalid), 32'd0);
        tick(3);
        check("ovr_hs_count", 32'(n_words - w0), 32'd1);
        check("ovr_hs_data", 32'(words[w0]), 32'h22);
        check("ovr_ferr", 32'(ferr_cycles - fe0), 32'd0);

        // Reset during data bit 3 of 0xC3, then 0x5A
        w0 = n_words; ov0 = ovr_cycles; fe0 = ferr_cycles;
        rxd = 1'b0;
        tick(8);
        rxd = 1'b1; tick(8);
        rxd = 1'b1; tick(8);
        rxd = 1'b0; tick(8);
        rxd = 1'b0; tick(4);
        rst_n = 1'b0;
        rxd   = 1'b1;
        tick(2);
        check("midrst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_tdata", 32'(m_axis_tdata), 32'd0);
        check("midrst_pulses", 32'({overrun_error, frame_error}), 32'd0);
        rst_n = 1'b1;
        tick(10);
        send_frame(8'h5A, 1'b1, t);
        tick(4);
        check("midrst_count", 32'(n_words - w0), 32'd1);
        check("midrst_data", 32'(words[w0]), 32'h5A);
        check("midrst_tvalid_edge", 32'(tv_rise), 32'(t + 78));
        check("midrst_errors", 32'((ovr_cycles - ov0) + (ferr_cycles - fe0)), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
